countdown_ctrl: RTL and testbench

Parametrised countdown controller: keypad-entered decimal value, countdown from `value*SCALE` on a 1 s tick, with pause/resume, abort and idle power-down. Successor of the fixed 2-digit/max-20 countdown logic: fully synchronous on one system clock, with keys and the 1 s tick as single-cycle enable pulses. It sits between the keypad debouncer/decoder and the 7-segment display driver.

---
 rtl/countdown_pkg.sv | 24 ++
 rtl/countdown_ctrl_idle_timer.sv | 36 +++
 rtl/countdown_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_countdown_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and width helpers for the countdown controller.
//   state_t   : controller state encoding
//   val_width : bits needed for the entered value (0..max_val)
//   rem_width : bits needed for the countdown value (0..max_val*scale)
package countdown_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_EMPTY,
        ST_ENTRY,
        ST_COUNT,
        ST_PAUSE
    } state_t;

    function automatic int unsigned val_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

    function automatic int unsigned rem_width(input int unsigned max_val,
                                              input int unsigned scale);
        return $clog2(max_val * scale + 1);
    endfunction

endpackage

// File: rtl/countdown_ctrl_idle_timer.sv
// Idle power-down timer: counts ticks while enabled and not cleared.
//   clk, rst : clock, async active-high reset
//   tick     : 1 s enable pulse
//   clear    : synchronous clear (wins over counting)
//   enable   : count ticks only while high
//   expire   : combinational, high on the tick that reaches IDLE_TIMEOUT
module idle_timer #(
    parameter int unsigned IDLE_TIMEOUT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(IDLE_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // Expire on the edge that would make the count reach the timeout, so the
    // owner can power down on that same edge.
    assign expire = enable && tick && !clear && (cnt == CNT_W'(IDLE_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || expire) begin
            cnt <= '0;
        end else if (enable && tick) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Keypad-driven countdown controller with pause/resume, abort and idle power-down.
//   clk, rst        : clock, async active-high reset
//   tick_1s         : one-cycle pulse per second
//   key_*           : one-cycle key pulses (priority clear>start>confirm>pause>num)
//   num             : digit, valid with key_num
//   display         : display enable
//   input_val       : entered value (saturates at MAX_VAL)
//   remaining       : countdown value
//   running, paused : high in COUNT / PAUSE
//   done            : one-cycle pulse on countdown expiry
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int unsigned MAX_DIGITS   = 2,
    parameter int unsigned MAX_VAL      = 20,
    parameter int unsigned SCALE        = 2,
    parameter int unsigned IDLE_TIMEOUT = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   tick_1s,
    input  logic                                   key_start,
    input  logic                                   key_clear,
    input  logic                                   key_confirm,
    input  logic                                   key_pause,
    input  logic                                   key_num,
    input  logic [3:0]                             num,
    output logic                                   display,
    output logic [val_width(MAX_VAL)-1:0]          input_val,
    output logic [rem_width(MAX_VAL, SCALE)-1:0]   remaining,
    output logic                                   running,
    output logic                                   paused,
    output logic                                   done
);

    localparam int unsigned VAL_W = val_width(MAX_VAL);
    localparam int unsigned REM_W = rem_width(MAX_VAL, SCALE);
    localparam int unsigned DIG_W = $clog2(MAX_DIGITS + 1);
    localparam int unsigned ACC_W = VAL_W + 4;

    state_t           state;
    logic [DIG_W-1:0] digits;
    logic             any_key;
    logic             in_entry;
    logic             digit_ok;
    logic             idle_expire;
    logic [ACC_W-1:0] acc_raw;
    logic [VAL_W-1:0] acc_val;
    logic [REM_W-1:0] acc_rem;
    logic [REM_W-1:0] rem_dec;

    assign any_key  = key_clear | key_start | key_confirm | key_pause | key_num;
    assign in_entry = (state == ST_EMPTY) || (state == ST_ENTRY);
    assign digit_ok = key_num && (num <= 4'd9);

    // Digit accumulation with saturation, and the matching countdown start.
    always_comb begin
        acc_raw = ACC_W'(input_val) * ACC_W'(10) + ACC_W'(num);
        acc_val = (acc_raw > ACC_W'(MAX_VAL)) ? VAL_W'(MAX_VAL) : acc_raw[VAL_W-1:0];
        acc_rem = REM_W'(acc_val) * REM_W'(SCALE);
        rem_dec = (remaining != '0) ? remaining - REM_W'(1) : '0;
    end

    // Only entry states time out; any key or leaving entry resets the count.
    idle_timer #(
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick_1s),
        .clear  (any_key || !in_entry),
        .enable (in_entry),
        .expire (idle_expire)
    );

    // Controller FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_OFF;
            digits    <= '0;
            display   <= 1'b0;
            input_val <= '0;
            remaining <= '0;
            running   <= 1'b0;
            paused    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_OFF: begin
                    if (key_start) begin
                        state     <= ST_EMPTY;
                        display   <= 1'b1;
                        input_val <= '0;
                        remaining <= '0;
                        digits    <= '0;
                    end
                end
                ST_EMPTY: begin
                    if (idle_expire) begin
                        state     <= ST_OFF;
                        display   <= 1'b0;
                        input_val <= '0;
                        remaining <= '0;
                        digits    <= '0;
                    end else if (digit_ok && (num != 4'd0)) begin
                        state     <= ST_ENTRY;
                        input_val <= acc_val;
                        remaining <= acc_rem;
                        digits    <= DIG_W'(1);
                    end
                end
                ST_ENTRY: begin
                    if (idle_expire) begin
                        state     <= ST_OFF;
                        display   <= 1'b0;
                        input_val <= '0;
                        remaining <= '0;
                        digits    <= '0;
                    end else if (key_clear) begin
                        state     <= ST_EMPTY;
                        input_val <= '0;
                        remaining <= '0;
                        digits    <= '0;
                    end else if (key_confirm) begin
                        state   <= ST_COUNT;
                        running <= 1'b1;
                    end else if (digit_ok && (digits < DIG_W'(MAX_DIGITS))) begin
                        input_val <= acc_val;
                        remaining <= acc_rem;
                        digits    <= digits + DIG_W'(1);
                    end
                end
                ST_COUNT: begin
                    // Clear aborts without decrement; otherwise the tick always
                    // applies first and expiry overrides any other key.
                    if (key_clear) begin
                        state     <= ST_EMPTY;
                        running   <= 1'b0;
                        input_val <= '0;
                        remaining <= '0;
                        digits    <= '0;
                    end else if (tick_1s && (rem_dec == '0)) begin
                        state     <= ST_EMPTY;
                        running   <= 1'b0;
                        input_val <= '0;
                        remaining <= '0;
                        digits    <= '0;
                        done      <= 1'b1;
                    end else begin
                        if (tick_1s) begin
                            remaining <= rem_dec;
                        end
                        if (key_pause) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                            paused  <= 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (key_clear) begin
                        state     <= ST_EMPTY;
                        paused    <= 1'b0;
                        input_val <= '0;
                        remaining <= '0;
                        digits    <= '0;
                    end else if (key_pause || key_confirm) begin
                        state   <= ST_COUNT;
                        paused  <= 1'b0;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_OFF;
                    display   <= 1'b0;
                    input_val <= '0;
                    remaining <= '0;
                    digits    <= '0;
                    running   <= 1'b0;
                    paused    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: two instances (default and 3-digit/999/x1) share
// stimulus; a behavioural model predicts both every cycle.
module tb_countdown_ctrl;

    localparam int IDLE = 10;
    localparam int K_CLR = 1, K_STA = 2, K_CNF = 4, K_PAU = 8, K_NUM = 16;
    localparam int S_OFF = 0, S_EMPTY = 1, S_ENTRY = 2, S_COUNT = 3, S_PAUSE = 4;

    logic clk = 1'b0;
    logic rst;
    logic tick_1s, key_start, key_clear, key_confirm, key_pause, key_num;
    logic [3:0] num;

    logic       d0_display, d0_running, d0_paused, d0_done;
    logic [4:0] d0_input_val;
    logic [5:0] d0_remaining;
    logic       d1_display, d1_running, d1_paused, d1_done;
    logic [9:0] d1_input_val;
    logic [9:0] d1_remaining;

    int n_checks = 0;
    int n_errors = 0;

    // Model: entered digits kept as an unclamped decimal number plus count.
    int m_st[2], m_nd[2], m_dv[2], m_rem[2], m_idle[2], m_disp[2], m_done[2];

    always #5 clk = ~clk;

    countdown_ctrl #(.MAX_DIGITS(2), .MAX_VAL(20), .SCALE(2), .IDLE_TIMEOUT(IDLE)) dut0 (
        .clk(clk), .rst(rst), .tick_1s(tick_1s), .key_start(key_start),
        .key_clear(key_clear), .key_confirm(key_confirm), .key_pause(key_pause),
        .key_num(key_num), .num(num), .display(d0_display), .input_val(d0_input_val),
        .remaining(d0_remaining), .running(d0_running), .paused(d0_paused), .done(d0_done)
    );

    countdown_ctrl #(.MAX_DIGITS(3), .MAX_VAL(999), .SCALE(1), .IDLE_TIMEOUT(IDLE)) dut1 (
        .clk(clk), .rst(rst), .tick_1s(tick_1s), .key_start(key_start),
        .key_clear(key_clear), .key_confirm(key_confirm), .key_pause(key_pause),
        .key_num(key_num), .num(num), .display(d1_display), .input_val(d1_input_val),
        .remaining(d1_remaining), .running(d1_running), .paused(d1_paused), .done(d1_done)
    );

    function automatic int p_md(input int i); return (i == 0) ? 2 : 3;    endfunction
    function automatic int p_mv(input int i); return (i == 0) ? 20 : 999; endfunction
    function automatic int p_sc(input int i); return (i == 0) ? 2 : 1;    endfunction

    function automatic int m_val(input int i);
        return (m_dv[i] > p_mv(i)) ? p_mv(i) : m_dv[i];
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = S_OFF; m_nd[i] = 0; m_dv[i] = 0; m_rem[i] = 0;
            m_idle[i] = 0; m_disp[i] = 0; m_done[i] = 0;
        end
    endtask

    task automatic m_to_empty(input int i);
        m_st[i] = S_EMPTY; m_nd[i] = 0; m_dv[i] = 0; m_rem[i] = 0;
    endtask

    task automatic m_push(input int i, input int d);
        m_dv[i]  = m_dv[i] * 10 + d;
        m_nd[i]  = m_nd[i] + 1;
        m_rem[i] = m_val(i) * p_sc(i);
    endtask

    // Next-state prediction from the inputs currently driven.
    task automatic model_step(input int i);
        bit anyk;
        int n;
        anyk = key_clear | key_start | key_confirm | key_pause | key_num;
        n = int'(num);
        m_done[i] = 0;
        case (m_st[i])
            S_OFF: begin
                if (key_start) begin
                    m_to_empty(i);
                    m_disp[i] = 1;
                end
            end
            S_EMPTY, S_ENTRY: begin
                if (anyk) m_idle[i] = 0;
                else if (tick_1s) m_idle[i] = m_idle[i] + 1;
                if (m_idle[i] >= IDLE) begin
                    m_to_empty(i);
                    m_st[i] = S_OFF; m_disp[i] = 0; m_idle[i] = 0;
                end else if (m_st[i] == S_EMPTY) begin
                    if (key_num && n >= 1 && n <= 9) begin
                        m_push(i, n);
                        m_st[i] = S_ENTRY;
                    end
                end else if (key_clear) begin
                    m_to_empty(i);
                end else if (key_confirm) begin
                    m_st[i] = S_COUNT;
                end else if (key_num && n <= 9 && m_nd[i] < p_md(i)) begin
                    m_push(i, n);
                end
            end
            S_COUNT: begin
                m_idle[i] = 0;
                if (key_clear) begin
                    m_to_empty(i);
                end else begin
                    if (tick_1s && m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        m_to_empty(i);
                        m_done[i] = 1;
                    end else if (key_pause) begin
                        m_st[i] = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                m_idle[i] = 0;
                if (key_clear) m_to_empty(i);
                else if (key_pause || key_confirm) m_st[i] = S_COUNT;
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        chk("d0.display",   int'(d0_display),   m_disp[0]);
        chk("d0.input_val", int'(d0_input_val), m_val(0));
        chk("d0.remaining", int'(d0_remaining), m_rem[0]);
        chk("d0.running",   int'(d0_running),   int'(m_st[0] == S_COUNT));
        chk("d0.paused",    int'(d0_paused),    int'(m_st[0] == S_PAUSE));
        chk("d0.done",      int'(d0_done),      m_done[0]);
        chk("d1.display",   int'(d1_display),   m_disp[1]);
        chk("d1.input_val", int'(d1_input_val), m_val(1));
        chk("d1.remaining", int'(d1_remaining), m_rem[1]);
        chk("d1.running",   int'(d1_running),   int'(m_st[1] == S_COUNT));
        chk("d1.paused",    int'(d1_paused),    int'(m_st[1] == S_PAUSE));
        chk("d1.done",      int'(d1_done),      m_done[1]);
    endtask

    // One clock of stimulus; called at a falling edge, returns at the next one.
    task automatic step(input int keys, input int n, input int t);
        key_clear   = (keys & K_CLR) != 0;
        key_start   = (keys & K_STA) != 0;
        key_confirm = (keys & K_CNF) != 0;
        key_pause   = (keys & K_PAU) != 0;
        key_num     = (keys & K_NUM) != 0;
        num         = 4'(n);
        tick_1s     = (t != 0);
        model_step(0);
        model_step(1);
        @(posedge clk);
        @(negedge clk);
        key_clear = 1'b0; key_start = 1'b0; key_confirm = 1'b0;
        key_pause = 1'b0; key_num = 1'b0; num = 4'd0; tick_1s = 1'b0;
        compare_all();
    endtask

    task automatic ticks(input int count);
        for (int k = 0; k < count; k++) step(0, 0, 1);
    endtask

    task automatic check_d0_zero(input string tag);
        chk({tag, ".display"},   int'(d0_display),   0);
        chk({tag, ".input_val"}, int'(d0_input_val), 0);
        chk({tag, ".remaining"}, int'(d0_remaining), 0);
        chk({tag, ".running"},   int'(d0_running),   0);
        chk({tag, ".paused"},    int'(d0_paused),    0);
        chk({tag, ".done"},      int'(d0_done),      0);
    endtask

    initial begin
        rst = 1'b1;
        key_clear = 1'b0; key_start = 1'b0; key_confirm = 1'b0;
        key_pause = 1'b0; key_num = 1'b0; num = 4'd0; tick_1s = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_d0_zero("reset");
        rst = 1'b0;
        compare_all();

        // Basic countdown from 15*2 = 30.
        step(K_STA, 0, 0);
        step(K_NUM, 1, 0);
        step(K_NUM, 5, 0);
        chk("a.input_val", int'(d0_input_val), 15);
        chk("a.remaining", int'(d0_remaining), 30);
        step(K_CNF, 0, 0);
        chk("a.running", int'(d0_running), 1);
        ticks(29);
        chk("a.rem_last", int'(d0_remaining), 1);
        chk("a.done_early", int'(d0_done), 0);
        step(0, 0, 1);
        chk("a.done", int'(d0_done), 1);
        chk("a.rem_zero", int'(d0_remaining), 0);
        chk("a.running_off", int'(d0_running), 0);
        chk("a.input_zero", int'(d0_input_val), 0);
        step(0, 0, 0);
        chk("a.done_once", int'(d0_done), 0);

        // Saturation, digit limit, and a leading zero ignored in EMPTY.
        step(K_STA, 0, 0);
        step(K_NUM, 3, 0);
        step(K_NUM, 7, 0);
        chk("b.input_sat", int'(d0_input_val), 20);
        chk("b.rem_sat", int'(d0_remaining), 40);
        step(K_NUM, 4, 0);
        chk("b.input_3rd", int'(d0_input_val), 20);
        chk("b.rem_3rd", int'(d0_remaining), 40);
        step(K_CLR, 0, 0);
        step(K_NUM, 0, 0);
        step(K_CNF, 0, 0);
        chk("b.zero_empty", int'(d0_running), 0);

        // Pause holds the count, confirm resumes it.
        step(K_NUM, 5, 0);
        chk("c.rem10", int'(d0_remaining), 10);
        step(K_CNF, 0, 0);
        ticks(3);
        step(K_PAU, 0, 0);
        chk("c.paused", int'(d0_paused), 1);
        ticks(5);
        chk("c.held", int'(d0_remaining), 7);
        step(K_CNF, 0, 0);
        chk("c.resumed", int'(d0_running), 1);
        ticks(6);
        chk("c.rem1", int'(d0_remaining), 1);
        step(0, 0, 1);
        chk("c.done", int'(d0_done), 1);

        // Idle power-down.
        step(K_STA, 0, 0);
        ticks(9);
        chk("d.on9", int'(d0_display), 1);
        step(K_NUM, 2, 1);
        chk("d.key_tick", int'(d0_display), 1);
        chk("d.input2", int'(d0_input_val), 2);
        ticks(9);
        chk("d.on19", int'(d0_display), 1);
        step(0, 0, 1);
        chk("d.off", int'(d0_display), 0);

        // Same-cycle collisions.
        step(K_STA, 0, 0);
        step(K_NUM, 1, 0);
        step(K_CNF, 0, 0);
        step(0, 0, 1);
        chk("e.rem1", int'(d0_remaining), 1);
        step(K_PAU, 0, 1);
        chk("e.expire_done", int'(d0_done), 1);
        chk("e.no_pause", int'(d0_paused), 0);
        step(K_STA, 0, 0);
        step(K_NUM, 4, 0);
        step(K_CLR | K_NUM, 3, 0);
        chk("e.clear_wins", int'(d0_input_val), 0);
        step(K_CNF, 0, 0);
        chk("e.is_empty", int'(d0_running), 0);

        // Wide instance: 999, then asynchronous reset mid-count.
        step(K_NUM, 9, 0);
        step(K_NUM, 9, 0);
        step(K_NUM, 9, 0);
        chk("f.d1_rem999", int'(d1_remaining), 999);
        chk("f.d1_val999", int'(d1_input_val), 999);
        step(K_CNF, 0, 0);
        ticks(5);
        chk("f.d1_rem994", int'(d1_remaining), 994);
        #2 rst = 1'b1;
        #1;
        chk("f.rst_display", int'(d1_display), 0);
        chk("f.rst_input", int'(d1_input_val), 0);
        chk("f.rst_rem", int'(d1_remaining), 0);
        chk("f.rst_running", int'(d1_running), 0);
        chk("f.rst_done", int'(d1_done), 0);
        check_d0_zero("f.rst_d0");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare_all();

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int keys;
            keys = 0;
            if ($urandom_range(0, 15) == 0) keys |= K_CLR;
            if ($urandom_range(0, 9)  == 0) keys |= K_STA;
            if ($urandom_range(0, 7)  == 0) keys |= K_CNF;
            if ($urandom_range(0, 7)  == 0) keys |= K_PAU;
            if ($urandom_range(0, 2)  == 0) keys |= K_NUM;
            step(keys, int'($urandom_range(0, 11)), int'($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
